// File: rtl/controle_rodada_nivel.sv
// -----------------------------------------------------------------------------
// controle_rodada_nivel
//
// Sub-controller for one level of the LED-matrix memory game. The top game
// FSM starts it with iniciar_nivel. It then sequences the level datapath:
//   - shows the stored sequence one element at a time (exibe) while stepping
//     the memory address counter M (zeraM / contaM);
//   - collects each player move (registraJ) and checks it with the comparator;
//   - times out a player who stays idle for too long.
// It reports the result with nivel_concluido (pulse), errou or timeout (held).
//
// Handshake: iniciar_nivel is a level request sampled on the rising edge and
// is accepted only while the block is in ocioso, est_errou or est_timeout.
// In any other state it is ignored. jogada is a one-cycle pulse and is
// consumed only in espera_jogada; elsewhere it is dropped, not queued.
//
// Ports
//   clock            in   rising-edge system clock
//   reset            in   asynchronous, active-high
//   iniciar_nivel    in   start level request
//   jogada           in   one-cycle pulse, player pressed a key
//   jogada_correta   in   comparator: registered move == memory[M]
//   fim_sequencia    in   M == current level length - 1
//   zeraM            out  clear move/address counter M
//   contaM           out  increment M
//   registraJ        out  load player-move register
//   exibe            out  drive the matrix with memory[M]
//   nivel_concluido  out  one-cycle pulse, whole sequence reproduced
//   errou            out  held while in est_errou
//   timeout          out  held while in est_timeout
//   pronto           out  high in ocioso
//   db_estado        out  state code for the debug display
// -----------------------------------------------------------------------------
module controle_rodada_nivel #(
    parameter int EXIBE_CICLOS   = 500,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar_nivel,
    input  logic       jogada,
    input  logic       jogada_correta,
    input  logic       fim_sequencia,
    output logic       zeraM,
    output logic       contaM,
    output logic       registraJ,
    output logic       exibe,
    output logic       nivel_concluido,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [4:0] db_estado
);

    // Timer sized for the longer of the two intervals it has to measure.
    localparam int MAX_CICLOS = (EXIBE_CICLOS > TIMEOUT_CICLOS) ? EXIBE_CICLOS : TIMEOUT_CICLOS;
    localparam int TW         = (MAX_CICLOS > 2) ? $clog2(MAX_CICLOS) : 1;

    localparam logic [TW-1:0] EXIBE_FIM   = TW'(EXIBE_CICLOS - 1);
    localparam logic [TW-1:0] TIMEOUT_FIM = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] TIMER_MAX   = '1;

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        INICIA        = 4'd1,
        MOSTRA        = 4'd2,
        PROX_MOSTRA   = 4'd3,
        PREPARA_JOGO  = 4'd4,
        ESPERA_JOGADA = 4'd5,
        REGISTRA      = 4'd6,
        COMPARA       = 4'd7,
        PROX_JOGADA   = 4'd8,
        CONCLUIDO     = 4'd9,
        EST_ERROU     = 4'd10,
        EST_TIMEOUT   = 4'd11
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;

    // ------------------------------------------------------------------
    // State and timer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO:        if (iniciar_nivel) estado_d = INICIA;
            INICIA:        estado_d = MOSTRA;
            MOSTRA:        if (timer_q == EXIBE_FIM) estado_d = PROX_MOSTRA;
            PROX_MOSTRA:   estado_d = fim_sequencia ? PREPARA_JOGO : MOSTRA;
            PREPARA_JOGO:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A move on the last allowed cycle still counts.
                if (jogada)                         estado_d = REGISTRA;
                else if (timer_q == TIMEOUT_FIM)    estado_d = EST_TIMEOUT;
            end
            REGISTRA:      estado_d = COMPARA;
            COMPARA: begin
                if (!jogada_correta)    estado_d = EST_ERROU;
                else if (fim_sequencia) estado_d = CONCLUIDO;
                else                    estado_d = PROX_JOGADA;
            end
            PROX_JOGADA:   estado_d = ESPERA_JOGADA;
            CONCLUIDO:     estado_d = OCIOSO;
            EST_ERROU:     if (iniciar_nivel) estado_d = INICIA;
            EST_TIMEOUT:   if (iniciar_nivel) estado_d = INICIA;
            default:       estado_d = OCIOSO;
        endcase
    end

    // ------------------------------------------------------------------
    // Timer: restarts from zero whenever mostra or espera_jogada is entered
    // (including mostra -> prox_mostra -> mostra), counts while the state is
    // held and saturates instead of wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        timer_d = timer_q;
        if (estado_d != estado_q) begin
            timer_d = '0;
        end else if ((estado_q == MOSTRA) || (estado_q == ESPERA_JOGADA)) begin
            if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Everything is decoded from the state, except that contaM in
    // prox_mostra is suppressed on the last element so M never runs past the
    // level length while the sequence is being shown.
    // ------------------------------------------------------------------
    always_comb begin
        zeraM           = 1'b0;
        contaM          = 1'b0;
        registraJ       = 1'b0;
        exibe           = 1'b0;
        nivel_concluido = 1'b0;
        errou           = 1'b0;
        timeout         = 1'b0;
        pronto          = 1'b0;
        db_estado       = {1'b0, estado_q};
        unique case (estado_q)
            OCIOSO: begin
                pronto = 1'b1;
                zeraM  = 1'b1;
            end
            INICIA:        zeraM           = 1'b1;
            MOSTRA:        exibe           = 1'b1;
            PROX_MOSTRA:   contaM          = ~fim_sequencia;
            PREPARA_JOGO:  zeraM           = 1'b1;
            ESPERA_JOGADA: ;
            REGISTRA:      registraJ       = 1'b1;
            COMPARA:       ;
            PROX_JOGADA:   contaM          = 1'b1;
            CONCLUIDO:     nivel_concluido = 1'b1;
            EST_ERROU:     errou           = 1'b1;
            EST_TIMEOUT:   timeout         = 1'b1;
            default:       db_estado       = 5'b11111;
        endcase
    end

endmodule

// File: tb/tb_controle_rodada_nivel.sv
module tb_controle_rodada_nivel;

  localparam int EXIBE   = 4;
  localparam int TMO     = 10;
  localparam int NLEVELS = 40;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic iniciar_nivel, jogada, jogada_correta, fim_sequencia;
  logic zeraM, contaM, registraJ, exibe, nivel_concluido, errou, timeout, pronto;
  logic [4:0] db_estado;

  controle_rodada_nivel #(.EXIBE_CICLOS(EXIBE), .TIMEOUT_CICLOS(TMO)) dut (
    .clock(clock), .reset(reset),
    .iniciar_nivel(iniciar_nivel), .jogada(jogada),
    .jogada_correta(jogada_correta), .fim_sequencia(fim_sequencia),
    .zeraM(zeraM), .contaM(contaM), .registraJ(registraJ), .exibe(exibe),
    .nivel_concluido(nivel_concluido), .errou(errou), .timeout(timeout),
    .pronto(pronto), .db_estado(db_estado)
  );

  // ---------------- scoreboard ----------------
  // Each entry is one clock cycle: the state the level should be in during
  // that cycle plus the inputs applied in it.
  typedef struct {
    int st;
    bit jog;
    bit ini;
    bit corr;
    bit rst;
    int len;
  } ent_t;

  ent_t exp_q[$];
  int   end_st;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Output table by state: {zeraM,contaM,registraJ,exibe,nivel_concluido,errou,timeout,pronto}
  function automatic logic [7:0] expected_outs(input int st, input bit fim);
    case (st)
      0:  return 8'b1000_0001;
      1:  return 8'b1000_0000;
      2:  return 8'b0001_0000;
      3:  return fim ? 8'b0000_0000 : 8'b0100_0000;
      4:  return 8'b1000_0000;
      6:  return 8'b0010_0000;
      8:  return 8'b0100_0000;
      9:  return 8'b0000_1000;
      10: return 8'b0000_0100;
      11: return 8'b0000_0010;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic bit idle_state(input int st);
    return (st == 0) || (st == 10) || (st == 11);
  endfunction

  // Ignored events are sprinkled wherever they must have no effect.
  task automatic push(input int st, input bit jog, input bit ini, input bit corr, input int len);
    ent_t e;
    e.st   = st;
    e.jog  = (st == 5) ? jog : ($urandom_range(0, 5) == 0);
    e.ini  = idle_state(st) ? ini : ($urandom_range(0, 7) == 0);
    e.corr = corr;
    e.rst  = 1'b0;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Expected cycle trace of one level, built from the level rules.
  task automatic gen_level(input int len);
    int  d;
    bit  corr;
    repeat ($urandom_range(0, 2)) push(end_st, 0, 0, 1, len);
    push(end_st, 0, 1, 1, len);                 // start request accepted here
    push(1, 0, 0, 1, len);
    for (int i = 0; i < len; i++) begin
      repeat (EXIBE) push(2, 0, 0, 1, len);
      push(3, 0, 0, 1, len);
    end
    push(4, 0, 0, 1, len);
    for (int j = 0; j < len; j++) begin
      corr = ($urandom_range(0, 5) != 0);
      d    = $urandom_range(0, 12);
      if (j == 0 && $urandom_range(0, 3) == 0) d = TMO - 1;  // move on the last allowed cycle
      if (d >= TMO) begin
        repeat (TMO) push(5, 0, 0, corr, len);
        end_st = 11;
        return;
      end
      repeat (d) push(5, 0, 0, corr, len);
      push(5, 1, 0, corr, len);
      push(6, 0, 0, corr, len);
      push(7, 0, 0, corr, len);
      if (!corr) begin
        end_st = 10;
        return;
      end
      if (j == len - 1) begin
        push(9, 0, 0, corr, len);
        end_st = 0;
        return;
      end
      push(8, 0, 0, corr, len);
    end
  endtask

  // Optionally cut the last level short with a reset in mostra or compara.
  task automatic maybe_abort(input int start);
    int cand[$];
    int idx;
    if ($urandom_range(0, 3) != 0) return;
    for (int k = start; k < exp_q.size(); k++)
      if (exp_q[k].st == 2 || exp_q[k].st == 7) cand.push_back(k);
    if (cand.size() == 0) return;
    idx = cand[$urandom_range(0, cand.size() - 1)];
    while (exp_q.size() > idx + 1) void'(exp_q.pop_back());
    exp_q[idx].rst = 1'b1;
    exp_q[idx].ini = 1'b0;
    end_st = 0;
  endtask

  // ---------------- main ----------------
  initial begin
    int   m;
    int   start;
    bit   fim;
    logic [7:0] eo;
    ent_t e;

    reset = 1'b1;
    iniciar_nivel = 1'b0; jogada = 1'b0; jogada_correta = 1'b0; fim_sequencia = 1'b0;

    end_st = 0;
    gen_level(1);
    gen_level(3);
    for (int l = 0; l < NLEVELS; l++) begin
      start = exp_q.size();
      gen_level($urandom_range(1, 4));
      maybe_abort(start);
    end
    repeat (3) push(end_st, 0, 0, 1, 1);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("reset_db_estado", {27'd0, db_estado}, 32'd0);
    check_val("reset_outs", {24'd0, zeraM, contaM, registraJ, exibe, nivel_concluido, errou, timeout, pronto},
              32'h81);
    reset = 1'b0;

    m = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e   = exp_q[i];
      fim = (m == e.len - 1);
      iniciar_nivel  = e.ini;
      jogada         = e.jog;
      jogada_correta = e.corr;
      fim_sequencia  = fim;
      #1;
      eo = expected_outs(e.st, fim);
      check_val($sformatf("db_estado@%0d", i), {27'd0, db_estado}, e.st);
      check_val($sformatf("outs@%0d", i),
                {24'd0, zeraM, contaM, registraJ, exibe, nivel_concluido, errou, timeout, pronto}, eo);
      if (eo[7])      m = 0;
      else if (eo[6]) m = m + 1;
      if (e.rst) begin
        #1 reset = 1'b1;
        #1;
        check_val($sformatf("abort_db_estado@%0d", i), {27'd0, db_estado}, 32'd0);
        check_val($sformatf("abort_outs@%0d", i),
                  {24'd0, zeraM, contaM, registraJ, exibe, nivel_concluido, errou, timeout, pronto}, 32'h81);
        #1 reset = 1'b0;
        iniciar_nivel = 1'b0;
        jogada        = 1'b0;
        m = 0;
      end
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
